mips_register_file: RTL
=======================

# mips_register_file

Multicycle MIPS general-purpose register file: the consumer of the write-back data selected by the 4:1 write-data mux. Thirty-one writable 32-bit registers plus hardwired `$zero`. Two read ports feed the A/B operand latches used by the following cycle's ALU step, and one debug read port serves the bench. All storage and both operand latches are clocked and asynchronously cleared.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)

Ports:
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all registers and latches
- RegWrite  in  1  write enable for write-back
- WriteRegister  in  ADDR_WIDTH  destination index (rd/rt/31 already selected upstream)
- WriteData  in  DATA_WIDTH  write-back value from the write-data mux
- LatchEn  in  1  when 1, A/B latches load this edge; when 0, they hold
- ReadRegister1  in  ADDR_WIDTH  rs index
- ReadRegister2  in  ADDR_WIDTH  rt index
- ReadData1  out  DATA_WIDTH  A latch (registered)
- ReadData2  out  DATA_WIDTH  B latch (registered)
- DebugAddr  in  ADDR_WIDTH  debug read index
- DebugData  out  DATA_WIDTH  combinational array[DebugAddr]; 0 when DebugAddr==0

## Operation
- Storage: regs[1..31]; index 0 not stored, always reads 0.
- Write: at posedge Clk, if RegWrite==1 and WriteRegister!=0, regs[WriteRegister] <= WriteData. Writes to index 0 are silently dropped.
- Read latch: at posedge Clk with LatchEn==1, ReadDataN <= value(ReadRegisterN).
- value(r) = 0 if r==0. Else, if RegWrite==1 and WriteRegister==r, WriteData (write-first bypass). Else regs[r].
- Both ports may name the same register. Both receive the same value, including the bypass case.
- LatchEn==0: ReadData1/2 hold; writes still occur.
- No arithmetic; data passes unmodified, full width, no sign handling.

## Timing
- Reset asserted (any time, including mid-cycle): regs[1..31], ReadData1, ReadData2 go to 0 immediately. DebugData follows combinationally (0).
- Reset deasserted: first rising edge behaves normally. A write presented on that edge takes effect.
- Write latency: 1 edge. DebugData reflects the new value right after the edge.
- Read latency: 1 edge from ReadRegisterN to ReadDataN. With bypass, a value written on edge k is visible in ReadDataN after edge k, not k+1.
- Reset asserted on the same edge as a write: reset wins; the register stays 0.
- Inputs are sampled only at the edge. Glitches between edges have no effect.

## Structure
- Shared package (mips_pkg): DATA_WIDTH/ADDR_WIDTH defaults; REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31 constants, also used by the write-register mux and control.
- One sub-module: mips_regfile_array. It holds the 31×32 storage, the write port and the combinational raw read ports (two operand ports and debug).
- Top level holds the bypass compare, the zero-index forcing and the A/B latches.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, assert Reset between edges -> ReadData1/2 and DebugData(r5) = 0 immediately. They stay 0 through the next edge while Reset is high.
- Zero register: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF -> DebugData(0)=0. ReadRegister1=0 gives ReadData1=0 after the next edge.
- Basic write/read: write 0x12345678 to r8. On a later edge, ReadRegister1=8, ReadRegister2=8, LatchEn=1 -> both outputs = 0x12345678 one edge later.
- Bypass: r9 holds 0x11111111. On the same edge, write 0x22222222 to r9 and read r9 on port 2 -> ReadData2 = 0x22222222 after that edge.
- Hold: latch r8 (0x12345678) on ReadData1. Then LatchEn=0, write 0xAAAAAAAA to r8 -> ReadData1 stays 0x12345678. DebugData(r8) = 0xAAAAAAAA.
- Sweep: write i*0x01010101 to r1..r31, then read all pairs -> every value matches, and r0 = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and well-known
// register indices used by the register file, write-register mux and control.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Operand ports on the register file: A (rs) and B (rt).
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } rf_port_e;

    localparam int NUM_READ_PORTS = 2;

endpackage

// File: rtl/mips_regfile_array.sv
// Register storage for r1..r(N-1) with one write port and three raw
// combinational read ports; index 0 has no storage and reads as zero.
module mips_regfile_array
    import mips_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] daddr,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] ddata
);

    localparam int NREG = 2 ** AW;

    // Flattened view of the file; entry 0 is tied to zero.
    logic [DW-1:0] word [NREG];

    assign word[0] = '0;

    // Flip-flop storage rather than block RAM: every entry must clear
    // asynchronously on Reset, which RAM primitives cannot do.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [DW-1:0] q_reg;
            logic          wr_hit;

            assign wr_hit = we && (waddr == AW'(gi));

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    q_reg <= '0;
                end else if (wr_hit) begin
                    q_reg <= wdata;
                end
            end

            assign word[gi] = q_reg;
        end
    endgenerate

    assign rdata1 = word[raddr1];
    assign rdata2 = word[raddr2];
    assign ddata  = word[daddr];

endmodule

// File: rtl/mips_register_file.sv
// MIPS GPR file: storage array plus write-first bypass, $zero forcing and
// the A/B operand latches consumed by the next ALU step.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  LatchEn,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] DebugAddr,
    output logic [DATA_WIDTH-1:0] DebugData
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr   [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] raw_data  [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_next   [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] latch_reg [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] debug_raw;

    // Writes to $zero are dropped here so the array never sees them.
    assign wr_en = RegWrite && (WriteRegister != '0);

    assign rd_addr[PORT_A] = ReadRegister1;
    assign rd_addr[PORT_B] = ReadRegister2;

    mips_regfile_array #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_array (
        .Clk    (Clk),
        .Reset  (Reset),
        .we     (wr_en),
        .waddr  (WriteRegister),
        .wdata  (WriteData),
        .raddr1 (rd_addr[PORT_A]),
        .raddr2 (rd_addr[PORT_B]),
        .daddr  (DebugAddr),
        .rdata1 (raw_data[PORT_A]),
        .rdata2 (raw_data[PORT_B]),
        .ddata  (debug_raw)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
            // Write-first: a register written on this edge is latched with
            // its new value, so the ALU step after sees it without a stall.
            always_comb begin
                rd_next[gi] = raw_data[gi];
                if (rd_addr[gi] == '0) begin
                    rd_next[gi] = '0;
                end else if (wr_en && (WriteRegister == rd_addr[gi])) begin
                    rd_next[gi] = WriteData;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    latch_reg[gi] <= '0;
                end else if (LatchEn) begin
                    latch_reg[gi] <= rd_next[gi];
                end
            end
        end
    endgenerate

    assign ReadData1 = latch_reg[PORT_A];
    assign ReadData2 = latch_reg[PORT_B];
    assign DebugData = (DebugAddr == '0) ? '0 : debug_raw;

endmodule
